// File: rtl/fp_arb_pkg.sv
// Shared definitions for the fp_add_arbiter block.
//   - state_e   : FSM state encoding (IDLE=0, ISSUE=1, FLUSH=2)
//   - NDefault  : default requester count
//   - BDefault  : default operand/result width
//   - LatDefault: default adder hold time in cycles
package fp_arb_pkg;

  localparam int unsigned NDefault   = 4;
  localparam int unsigned BDefault   = 32;
  localparam int unsigned LatDefault = 48;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StFlush = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot selector.
// Ports:
//   req_i [N]  : request vector
//   ptr_i [PW] : index with highest priority this cycle
//   gnt_o [N]  : one-hot grant (all zero when no request)
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic [N-1:0]   rot;
  logic [N-1:0]   rot_gnt;
  logic [2*N-1:0] gnt2;
  logic           found;

  // Rotate so the pointer index sits at bit 0, pick the lowest set bit,
  // then rotate the one-hot result back.
  always_comb begin
    rot     = N'({req_i, req_i} >> ptr_i);
    rot_gnt = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        rot_gnt[i] = 1'b1;
        found      = 1'b1;
      end
    end
    gnt2  = {{N{1'b0}}, rot_gnt} << ptr_i;
    gnt_o = gnt2[N-1:0] | gnt2[2*N-1:N];
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one multi-cycle floating-point adder among N requesters.
// One operation is in flight at a time: IDLE (grant) -> ISSUE (LAT cycles, adder
// enabled) -> FLUSH (adder disabled, result strobe) -> IDLE.
// Optional feature macro: FP_ARB_ZERO_BYPASS_EN -- an operand equal to +0 skips
// ISSUE and returns the other operand directly.
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-low reset
//   req_i  [N]   : per-requester level request, held until granted
//   a_i/b_i[N*B] : packed operands, slice k for requester k
//   gnt_o  [N]   : one-hot grant pulse, operands latched this cycle
//   add_en_o     : shared adder enable
//   add_g1_o/add_g2_o [B] : adder operands
//   add_sum_i [B]: adder result
//   res_valid_o  : one-cycle result strobe
//   res_o [B], res_id_o : result and originating requester index
//   busy_o       : high whenever the FSM is not in IDLE
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int unsigned N   = NDefault,
  parameter int unsigned B   = BDefault,
  parameter int unsigned LAT = LatDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         req_i,
  input  logic [N*B-1:0]       a_i,
  input  logic [N*B-1:0]       b_i,
  output logic [N-1:0]         gnt_o,
  output logic                 add_en_o,
  output logic [B-1:0]         add_g1_o,
  output logic [B-1:0]         add_g2_o,
  input  logic [B-1:0]         add_sum_i,
  output logic                 res_valid_o,
  output logic [B-1:0]         res_o,
  output logic [$clog2(N)-1:0] res_id_o,
  output logic                 busy_o
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(LAT);

  state_e        state_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] id_q;
  logic [IW-1:0] res_id_q;
  logic [CW-1:0] cnt_q;
  logic [B-1:0]  op_a_q;
  logic [B-1:0]  op_b_q;
  logic [B-1:0]  res_q;
  logic          add_en_q;
  logic          res_valid_q;

  logic [N-1:0]  arb_gnt;
  logic [IW-1:0] gnt_idx;
  logic [B-1:0]  sel_a;
  logic [B-1:0]  sel_b;
  logic          grant;

  rr_arbiter #(
    .N  (N),
    .PW (IW)
  ) u_rr_arbiter (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  // Grant is suppressed during reset so no operand latch can be lost.
  always_comb begin
    grant   = rst_i && (state_q == StIdle) && (|req_i);
    gnt_idx = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (arb_gnt[i]) begin
        gnt_idx = IW'(i);
        sel_a   = a_i[i*B +: B];
        sel_b   = b_i[i*B +: B];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      id_q        <= '0;
      res_id_q    <= '0;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_q       <= '0;
      add_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            op_a_q <= sel_a;
            op_b_q <= sel_b;
            id_q   <= gnt_idx;
            ptr_q  <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
            cnt_q  <= '0;
`ifdef FP_ARB_ZERO_BYPASS_EN
            if ((sel_a == '0) || (sel_b == '0)) begin
              // Adding +0 is the identity; both zero yields sel_b = 0.
              res_q       <= (sel_a == '0) ? sel_b : sel_a;
              res_id_q    <= gnt_idx;
              res_valid_q <= 1'b1;
              state_q     <= StFlush;
            end else begin
              add_en_q <= 1'b1;
              state_q  <= StIssue;
            end
`else
            add_en_q <= 1'b1;
            state_q  <= StIssue;
`endif
          end
        end
        StIssue: begin
          if (cnt_q == CW'(LAT - 1)) begin
            res_q       <= add_sum_i;
            res_id_q    <= id_q;
            res_valid_q <= 1'b1;
            add_en_q    <= 1'b0;
            state_q     <= StFlush;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFlush: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign gnt_o       = grant ? arb_gnt : '0;
  assign add_en_o    = add_en_q;
  assign add_g1_o    = op_a_q;
  assign add_g2_o    = op_b_q;
  assign res_valid_o = res_valid_q;
  assign res_o       = res_q;
  assign res_id_o    = res_id_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter (N=4, B=32, LAT=48). A small adder stub
// supplies add_sum_i: the known pair 1.0 + 2.0 returns 3.0, any other pair
// returns g1 ^ g2, and a disabled adder returns a poison value.
module tb_fp_add_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned B   = 32;
  localparam int unsigned LAT = 48;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*B-1:0] a;
  logic [N*B-1:0] b;
  logic [N-1:0]   gnt;
  logic           add_en;
  logic [B-1:0]   g1;
  logic [B-1:0]   g2;
  logic [B-1:0]   sum;
  logic           res_valid;
  logic [B-1:0]   res;
  logic [1:0]     res_id;
  logic           busy;

  int checks = 0;
  int errors = 0;

  fp_add_arbiter #(
    .N   (N),
    .B   (B),
    .LAT (LAT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .a_i         (a),
    .b_i         (b),
    .gnt_o       (gnt),
    .add_en_o    (add_en),
    .add_g1_o    (g1),
    .add_g2_o    (g2),
    .add_sum_i   (sum),
    .res_valid_o (res_valid),
    .res_o       (res),
    .res_id_o    (res_id),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [B-1:0] adder_stub(input logic [B-1:0] x, input logic [B-1:0] y);
    if (x == 32'h3F800000 && y == 32'h40000000) return 32'h40400000;
    return x ^ y;
  endfunction

  assign sum = add_en ? adder_stub(g1, g2) : 32'hDEADBEEF;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    req = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req = 4'b1111;
    a   = '1;
    b   = '1;
    repeat (3) tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (add_en !== 1'b0) begin errors++; $display("FAIL reset_add_en: got %b expected 0", add_en); end
    checks++; if (g1 !== 32'h0) begin errors++; $display("FAIL reset_g1: got %h expected 0", g1); end
    checks++; if (g2 !== 32'h0) begin errors++; $display("FAIL reset_g2: got %h expected 0", g2); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL reset_res: got %h expected 0", res); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_res_id: got %0d expected 0", res_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    req = '0;
    a   = '0;
    b   = '0;
    rst = 1'b1;
    tick();
  endtask

  // 1.0 + 2.0 from requester 0; operands change after grant to prove latching.
  task automatic test_basic;
    int en_cnt, first_en, valid_at, valid_cnt;
    a[31:0] = 32'h3F800000;
    b[31:0] = 32'h40000000;
    req     = 4'b0001;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL basic_gnt: got %b expected 0001", gnt); end
    tick();
    req       = '0;
    a[31:0]   = 32'h12345678;
    b[31:0]   = 32'h9ABCDEF0;
    en_cnt    = 0;
    first_en  = -1;
    valid_at  = -1;
    valid_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 1) begin
        checks++; if (g1 !== 32'h3F800000) begin errors++; $display("FAIL basic_g1: got %h expected 3f800000", g1); end
        checks++; if (g2 !== 32'h40000000) begin errors++; $display("FAIL basic_g2: got %h expected 40000000", g2); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
      end
      if (add_en === 1'b1) begin
        en_cnt++;
        if (first_en < 0) first_en = k;
      end
      if (res_valid === 1'b1) begin
        valid_cnt++;
        if (valid_at < 0) valid_at = k;
      end
      tick();
    end
    checks++; if (first_en != 1) begin errors++; $display("FAIL basic_en_start: got T+%0d expected T+1", first_en); end
    checks++; if (en_cnt != 48) begin errors++; $display("FAIL basic_en_cycles: got %0d expected 48", en_cnt); end
    checks++; if (valid_at != 49) begin errors++; $display("FAIL basic_valid_time: got T+%0d expected T+49", valid_at); end
    checks++; if (valid_cnt != 1) begin errors++; $display("FAIL basic_valid_pulses: got %0d expected 1", valid_cnt); end
    checks++; if (res !== 32'h40400000) begin errors++; $display("FAIL basic_res: got %h expected 40400000", res); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL basic_res_id: got %0d expected 0", res_id); end
  endtask

  // All four requesting: order 0,1,2,3,0 every 50 cycles; each gap between
  // adder windows is the FLUSH cycle plus the next grant cycle.
  task automatic test_round_robin;
    int gcyc[5];
    logic [N-1:0] gval[5];
    logic [N-1:0] exp_g;
    int ngr, gap, gap_valid;
    logic en_prev, seen_window;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      a[k*B +: B] = 32'h41000000 + k;
      b[k*B +: B] = 32'h00000010 << k;
    end
    for (int i = 0; i < 5; i++) begin
      gcyc[i] = -1;
      gval[i] = '0;
    end
    ngr         = 0;
    gap         = 0;
    gap_valid   = 0;
    en_prev     = 1'b0;
    seen_window = 1'b0;
    req         = 4'b1111;
    #1;
    for (int c = 0; c < 260; c++) begin
      if (gnt !== 4'b0000 && ngr < 5) begin
        gcyc[ngr] = c;
        gval[ngr] = gnt;
        ngr++;
      end
      if (add_en === 1'b1) begin
        if (seen_window && !en_prev) begin
          checks++; if (gap != 2 || gap_valid != 1) begin
            errors++;
            $display("FAIL rr_gap: got %0d idle cycles with %0d strobes expected 2 with 1", gap, gap_valid);
          end
        end
        seen_window = 1'b1;
        gap         = 0;
        gap_valid   = 0;
      end else if (seen_window) begin
        gap++;
        if (res_valid === 1'b1) gap_valid++;
      end
      en_prev = add_en;
      tick();
    end
    req = '0;
    checks++; if (ngr != 5) begin errors++; $display("FAIL rr_count: got %0d grants expected 5", ngr); end
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      checks++; if (gval[i] !== exp_g) begin errors++; $display("FAIL rr_order[%0d]: got %b expected %b", i, gval[i], exp_g); end
      checks++; if (gcyc[i] != 50 * i) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d expected %0d", i, gcyc[i], 50 * i); end
    end
  endtask

  task automatic test_wait_while_busy;
    int bad, first;
    logic [N-1:0] fval;
    do_reset();
    a[31:0] = 32'h3F800000;
    b[31:0] = 32'h40000000;
    a[95:64] = 32'h40400000;
    b[95:64] = 32'h00000001;
    req = 4'b0001;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL busy_first_gnt: got %b expected 0001", gnt); end
    tick();
    req   = '0;
    bad   = 0;
    first = -1;
    fval  = '0;
    for (int c = 1; c <= 80; c++) begin
      if (c == 5) begin
        req[2] = 1'b1;
        #1;
      end
      if (gnt !== 4'b0000) begin
        if (c < 50) bad++;
        if (first < 0) begin
          first = c;
          fval  = gnt;
        end
      end
      tick();
    end
    req = '0;
    checks++; if (bad != 0) begin errors++; $display("FAIL busy_no_grant: got %0d grants while busy expected 0", bad); end
    checks++; if (first != 50) begin errors++; $display("FAIL busy_grant_time: got T+%0d expected T+50", first); end
    checks++; if (fval !== 4'b0100) begin errors++; $display("FAIL busy_grant_value: got %b expected 0100", fval); end
  endtask

  task automatic test_reset_mid_op;
    int vcnt;
    do_reset();
    a[63:32] = 32'h3F800000;
    b[63:32] = 32'h3F800000;
    req = 4'b0010;
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rmid_gnt: got %b expected 0010", gnt); end
    tick();
    req = '0;
    repeat (9) tick();
    rst = 1'b0;
    tick();
    checks++; if (add_en !== 1'b0) begin errors++; $display("FAIL rmid_add_en: got %b expected 0", add_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    vcnt = 0;
    for (int c = 11; c <= 70; c++) begin
      if (c == 12) rst = 1'b1;
      if (res_valid === 1'b1) vcnt++;
      tick();
    end
    checks++; if (vcnt != 0) begin errors++; $display("FAIL rmid_no_result: got %0d strobes expected 0", vcnt); end
    req = 4'b1111;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rmid_next_gnt: got %b expected 0001", gnt); end
    tick();
    req = '0;
  endtask

  task automatic test_zero_operand;
    int en_cnt, valid_at;
    do_reset();
    a[31:0] = 32'h00000000;
    b[31:0] = 32'h40A00000;
    req     = 4'b0001;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL zero_gnt: got %b expected 0001", gnt); end
    tick();
    req      = '0;
    en_cnt   = 0;
    valid_at = -1;
    for (int k = 1; k <= 60; k++) begin
      if (add_en === 1'b1) en_cnt++;
      if (res_valid === 1'b1 && valid_at < 0) valid_at = k;
      tick();
    end
`ifdef FP_ARB_ZERO_BYPASS_EN
    checks++; if (valid_at != 1) begin errors++; $display("FAIL zero_valid_time: got T+%0d expected T+1", valid_at); end
    checks++; if (en_cnt != 0) begin errors++; $display("FAIL zero_en_cycles: got %0d expected 0", en_cnt); end
`else
    checks++; if (valid_at != 49) begin errors++; $display("FAIL zero_valid_time: got T+%0d expected T+49", valid_at); end
    checks++; if (en_cnt != 48) begin errors++; $display("FAIL zero_en_cycles: got %0d expected 48", en_cnt); end
`endif
    checks++; if (res !== 32'h40A00000) begin errors++; $display("FAIL zero_res: got %h expected 40a00000", res); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL zero_res_id: got %0d expected 0", res_id); end
  endtask

  initial begin
    rst = 1'b0;
    req = '0;
    a   = '0;
    b   = '0;
    test_reset();
    test_basic();
    test_round_robin();
    test_wait_while_busy();
    test_reset_mid_op();
    test_zero_operand();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
